// File: rtl/mux_n_reg_if.sv
// Handshake bundle between N producers, the mux_n_reg selector and its single consumer.
// The slave modport is the selector's view; master is the producer/consumer side.
interface mux_n_reg_if #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
);
  logic [NUM_INPUTS*WIDTH-1:0] inputs;
  logic [NUM_INPUTS-1:0]       inValid;
  logic [NUM_INPUTS-1:0]       inReady;
  logic [SEL_WIDTH-1:0]        selection;
  logic                        mode;
  logic [WIDTH-1:0]            outData;
  logic                        outValid;
  logic                        outReady;
  logic [SEL_WIDTH-1:0]        outSource;

  modport slave (
    input  inputs, inValid, selection, mode, outReady,
    output inReady, outData, outValid, outSource
  );

  modport master (
    output inputs, inValid, selection, mode, outReady,
    input  inReady, outData, outValid, outSource
  );
endinterface

// File: rtl/mux_n_reg.sv
// Parametrised N:1 registered selector with valid/ready handshake, explicit or round-robin grant.
// Optional MUX_N_REG_COUNT_EN adds a saturating 16-bit count of loads (o_transferCount).
module mux_n_reg #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mux_n_reg_if.slave  io_bus
`ifdef MUX_N_REG_COUNT_EN
  ,
  output logic [15:0] o_transferCount
`endif
);

  logic [WIDTH-1:0]     r_outData;
  logic                 r_outValid;
  logic [SEL_WIDTH-1:0] r_outSource;
  logic [SEL_WIDTH-1:0] r_ptr;

  logic                 w_canLoad;
  logic                 w_grantValid;
  logic [SEL_WIDTH-1:0] w_grantIdx;
  logic                 w_load;
  logic [SEL_WIDTH-1:0] w_ptrNext;
  logic [WIDTH-1:0]     w_selData;

  assign w_canLoad = !r_outValid || io_bus.outReady;
  assign w_load    = w_canLoad && w_grantValid;

  // Round-robin: later passes override earlier ones, so the lowest valid index at or
  // above the pointer wins, falling back to the lowest valid index below it.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    if (!io_bus.mode) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (io_bus.selection == SEL_WIDTH'(i) && io_bus.inValid[i]) begin
          w_grantValid = 1'b1;
          w_grantIdx   = SEL_WIDTH'(i);
        end
      end
    end else begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (io_bus.inValid[i] && SEL_WIDTH'(i) < r_ptr) begin
          w_grantValid = 1'b1;
          w_grantIdx   = SEL_WIDTH'(i);
        end
      end
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (io_bus.inValid[i] && SEL_WIDTH'(i) >= r_ptr) begin
          w_grantValid = 1'b1;
          w_grantIdx   = SEL_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    w_selData      = '0;
    io_bus.inReady = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_grantIdx == SEL_WIDTH'(i)) begin
        w_selData         = io_bus.inputs[i*WIDTH +: WIDTH];
        io_bus.inReady[i] = w_load;
      end
    end
  end

  assign w_ptrNext = (w_grantIdx == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                                 : w_grantIdx + SEL_WIDTH'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_outData   <= '0;
      r_outValid  <= 1'b0;
      r_outSource <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_outData   <= w_selData;
      r_outSource <= w_grantIdx;
      r_outValid  <= 1'b1;
      if (io_bus.mode) begin
        r_ptr <= w_ptrNext;
      end
    end else if (io_bus.outReady) begin
      r_outValid <= 1'b0;
    end
  end

  assign io_bus.outData   = r_outData;
  assign io_bus.outValid  = r_outValid;
  assign io_bus.outSource = r_outSource;

`ifdef MUX_N_REG_COUNT_EN
  logic [15:0] r_transferCount;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_transferCount <= '0;
    end else if (w_load && r_transferCount != 16'hFFFF) begin
      r_transferCount <= r_transferCount + 16'd1;
    end
  end

  assign o_transferCount = r_transferCount;
`endif

endmodule
